// File: rtl/dmux_n_reg.sv
// Registered 1-to-N demultiplexer with a one-entry valid/ready holding register per channel,
// broadcast mode, and a saturating counter of words dropped for an out-of-range select.
module dmux_n_reg #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned DROP_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            din,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        bcast,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [CHANNELS*WIDTH-1:0]   out_data,
  output logic [CHANNELS-1:0]         out_valid,
  input  logic [CHANNELS-1:0]         out_ready,
  output logic [DROP_W-1:0]           drop_cnt
);

  logic [WIDTH-1:0]    data_q [CHANNELS];
  logic [WIDTH-1:0]    data_d [CHANNELS];
  logic [CHANNELS-1:0] valid_q, valid_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] sel_hit;
  logic [CHANNELS-1:0] load;
  logic                sel_in_range;
  logic                accept;

  // Decoding sel against each channel index avoids indexing past CHANNELS when sel is out of range.
  always_comb begin
    free    = '0;
    sel_hit = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      free[i]    = !valid_q[i] || out_ready[i];
      sel_hit[i] = (sel == SEL_W'(i));
    end
    sel_in_range = |sel_hit;
  end

  always_comb begin
    in_ready = 1'b1;
    if (bcast)
      in_ready = &free;
    else if (sel_in_range)
      in_ready = |(free & sel_hit);
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    load = '0;
    if (accept)
      load = bcast ? '1 : sel_hit;
  end

  always_comb begin
    valid_d    = valid_q & ~out_ready;
    drop_cnt_d = drop_cnt_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      data_d[i] = data_q[i];
      if (load[i]) begin
        data_d[i]  = din;
        valid_d[i] = 1'b1;
      end
    end
    if (accept && !bcast && !sel_in_range && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      drop_cnt_q <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++)
        data_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      drop_cnt_q <= drop_cnt_d;
      for (int unsigned i = 0; i < CHANNELS; i++)
        data_q[i] <= data_d[i];
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < CHANNELS; i++)
      out_data[i*WIDTH +: WIDTH] = data_q[i];
  end

  assign out_valid = valid_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_dmux_n_reg.sv
// Directed bench for dmux_n_reg: a reference model predicts in_ready/out_valid and per-channel
// scoreboard queues hold expected words, popped when a channel drains.
module tb_dmux_n_reg;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  din;
  logic [2:0]   sel;
  logic         bcast;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [7:0]   out_valid;
  logic [7:0]   out_ready;
  logic [7:0]   drop_cnt;

  logic [15:0]  din6;
  logic [2:0]   sel6;
  logic         bcast6;
  logic         in_valid6;
  logic         in_ready6;
  logic [95:0]  out_data6;
  logic [5:0]   out_valid6;
  logic [5:0]   out_ready6;
  logic [1:0]   drop_cnt6;

  always #5 clk = ~clk;

  dmux_n_reg u_dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .bcast(bcast),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  dmux_n_reg #(.WIDTH(16), .SEL_W(3), .CHANNELS(6), .DROP_W(2)) u_dut6 (
    .clk(clk), .rst(rst), .din(din6), .sel(sel6), .bcast(bcast6),
    .in_valid(in_valid6), .in_ready(in_ready6), .out_data(out_data6),
    .out_valid(out_valid6), .out_ready(out_ready6), .drop_cnt(drop_cnt6)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [15:0] sb [8][$];
  logic [7:0]  mv = '0;
  int unsigned delivered1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_model();
    mv = '0;
    for (int i = 0; i < 8; i++) sb[i].delete();
  endtask

  // One clock of the main DUT: inputs are already driven (just after a falling edge).
  task automatic cycle();
    logic [7:0]  fr;
    logic [7:0]  nv;
    logic        exp_rdy;
    int unsigned s;
    #1;
    for (int i = 0; i < 8; i++) fr[i] = !mv[i] || out_ready[i];
    s = int'(sel);
    exp_rdy = bcast ? &fr : fr[s];
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    for (int i = 0; i < 8; i++) begin
      if (mv[i] && out_ready[i]) begin
        if (sb[i].size() == 0) begin
          chk($sformatf("sb_empty_ch%0d", i), 32'd1, 32'd0);
        end else begin
          chk($sformatf("deliver_ch%0d", i), {16'd0, out_data[i*16 +: 16]}, {16'd0, sb[i].pop_front()});
          if (i == 1) delivered1++;
        end
      end
    end
    nv = mv & ~out_ready;
    if (in_valid && exp_rdy) begin
      if (bcast) begin
        for (int i = 0; i < 8; i++) sb[i].push_back(din);
        nv = '1;
      end else begin
        sb[s].push_back(din);
        nv[s] = 1'b1;
      end
    end
    @(posedge clk);
    mv = nv;
    #1;
    chk("out_valid", {24'd0, out_valid}, {24'd0, mv});
    chk("drop_cnt", {24'd0, drop_cnt}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] oor_sel [5];
    oor_sel = '{3'd6, 3'd7, 3'd6, 3'd7, 3'd6};
    rst = 1'b1; din = '0; sel = '0; bcast = 1'b0; in_valid = 1'b0; out_ready = '0;
    din6 = 16'h7777; sel6 = '0; bcast6 = 1'b0; in_valid6 = 1'b0; out_ready6 = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", {24'd0, out_valid}, 32'd0);
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_data_ch%0d", i), {16'd0, out_data[i*16 +: 16]}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Sweep sel 0..7 with every consumer ready.
    din = 16'hA5A5; in_valid = 1'b1; out_ready = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      cycle();
    end
    in_valid = 1'b0;
    cycle();

    // Back-pressure on channel 3.
    out_ready = 8'hF7; sel = 3'd3; in_valid = 1'b1; din = 16'h1111;
    cycle();
    din = 16'h2222;
    cycle();
    cycle();
    chk("bp_hold_ch3", {16'd0, out_data[3*16 +: 16]}, 32'h1111);
    out_ready = 8'hFF;
    cycle();
    in_valid = 1'b0;
    cycle();

    // Broadcast blocked by a full, stalled channel 5, then released.
    out_ready = 8'hDF; sel = 3'd5; din = 16'h5555; in_valid = 1'b1;
    cycle();
    bcast = 1'b1; din = 16'hBEEF;
    cycle();
    out_ready = 8'hFF;
    cycle();
    for (int i = 0; i < 8; i++) chk($sformatf("bcast_ch%0d", i), {16'd0, out_data[i*16 +: 16]}, 32'hBEEF);
    bcast = 1'b0; in_valid = 1'b0;
    cycle();

    // Out-of-range select on the 6-channel instance; 2-bit counter saturates at 3.
    in_valid6 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sel6 = oor_sel[k];
      #1;
      chk("oor_in_ready", {31'd0, in_ready6}, 32'd1);
      @(posedge clk);
      #1;
      chk("oor_out_valid", {26'd0, out_valid6}, 32'd0);
      chk("oor_drop_cnt", {30'd0, drop_cnt6}, (k < 3) ? k + 1 : 3);
      @(negedge clk);
    end
    in_valid6 = 1'b0;

    // Reset while channels 0 and 2 hold words and a new word is offered.
    out_ready = 8'h00; in_valid = 1'b1; sel = 3'd0; din = 16'h0A0A;
    cycle();
    sel = 3'd2; din = 16'h0C0C;
    cycle();
    rst = 1'b1; sel = 3'd4; din = 16'hDEAD;
    @(posedge clk);
    #1;
    chk("mid_rst_out_valid", {24'd0, out_valid}, 32'd0);
    chk("mid_rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
    chk("mid_rst_drop_cnt6", {30'd0, drop_cnt6}, 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("mid_rst_data_ch%0d", i), {16'd0, out_data[i*16 +: 16]}, 32'd0);
    clear_model();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    cycle();

    // Back-to-back drain and load on channel 1.
    out_ready = 8'hFF; sel = 3'd1; in_valid = 1'b1;
    delivered1 = 0;
    for (int k = 0; k < 10; k++) begin
      din = 16'h0100 + 16'(k);
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    chk("ch1_delivered", delivered1, 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
